// File: rtl/mux4_scan_pkg.sv
// Shared types and channel-walk helpers for the 4:1 mux scan sequencer.
// Latency: n/a (declarations only). Backpressure: n/a.
package mux4_scan_pkg;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

    // Lowest enabled channel; the first one visited in a frame.
    function automatic logic [CH_W-1:0] first_ch(input logic [NUM_CH-1:0] mask);
        logic [CH_W-1:0] c;
        c = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) c = CH_W'(i);
        end
        return c;
    endfunction

    // Highest enabled channel; leaving it ends the frame.
    function automatic logic [CH_W-1:0] last_ch(input logic [NUM_CH-1:0] mask);
        logic [CH_W-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (mask[i]) c = CH_W'(i);
        end
        return c;
    endfunction

    function automatic logic [CH_W-1:0] next_ch(input logic [NUM_CH-1:0] mask,
                                                input logic [CH_W-1:0]   ch);
        logic [CH_W-1:0] c;
        logic            found;
        c     = ch;
        found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found && (i > int'(ch)) && mask[i]) begin
                c     = CH_W'(i);
                found = 1'b1;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/mux4_dwell_timer.sv
// Per-channel dwell counter 0..DWELL-1 with settle/last strobes.
// Latency: strobes are combinational from the count. Backpressure: none.
module mux4_dwell_timer #(
    parameter int DWELL  = 4,
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic at_settle,
    output logic at_last
);

    logic [7:0] dwell_cnt;

    assign at_settle = (dwell_cnt == 8'(SETTLE));
    assign at_last   = (dwell_cnt == 8'(DWELL - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            dwell_cnt <= '0;
        end else if (en) begin
            dwell_cnt <= at_last ? 8'd0 : dwell_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/mux4_scan_ctrl.sv
// Walks {s1,s0} over the mux channels and publishes each frame; CH_MASK_EN adds ch_mask.
// Latency: frame result registered one cycle after its last dwell. Backpressure: none, free-running.
module mux4_scan_ctrl
    import mux4_scan_pkg::*;
#(
    parameter int DWELL  = 4,
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              mux_out,
`ifdef CH_MASK_EN
    input  logic [NUM_CH-1:0] ch_mask,
`endif
    output logic              s0,
    output logic              s1,
    output logic [NUM_CH-1:0] sample,
    output logic              sample_valid,
    output logic              busy,
    output logic [7:0]        frame_cnt
);

    scan_state_t       state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [NUM_CH-1:0] shadow_q, shadow_d;
    logic [NUM_CH-1:0] sample_q, sample_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [NUM_CH-1:0] mask_in, frame_bits;
    logic              stop_pend_q, stop_pend_d;
    logic              valid_q, valid_d;
    logic [7:0]        fcnt_q, fcnt_d;
    logic              tmr_clr, tmr_en, at_settle, at_last;

`ifdef CH_MASK_EN
    assign mask_in = ch_mask;
`else
    assign mask_in = '1;
`endif

    mux4_dwell_timer #(.DWELL(DWELL), .SETTLE(SETTLE)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clr       (tmr_clr),
        .en        (tmr_en),
        .at_settle (at_settle),
        .at_last   (at_last)
    );

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        shadow_d    = shadow_q;
        sample_d    = sample_q;
        mask_d      = mask_q;
        stop_pend_d = stop_pend_q;
        valid_d     = 1'b0;
        fcnt_d      = fcnt_q;
        tmr_clr     = 1'b0;
        tmr_en      = 1'b0;
        frame_bits  = shadow_q;
        case (state_q)
            IDLE: begin
                if (start && (|mask_in)) begin
                    state_d     = SCAN;
                    ch_d        = first_ch(mask_in);
                    mask_d      = mask_in;
                    shadow_d    = '0;
                    stop_pend_d = stop;
                    tmr_clr     = 1'b1;
                end
            end
            SCAN: begin
                tmr_en = 1'b1;
                if (stop) stop_pend_d = 1'b1;
                // Merging the live sample here covers SETTLE == DWELL-1 on the last channel.
                if (at_settle) frame_bits[ch_q] = mux_out;
                shadow_d = frame_bits;
                if (at_last) begin
                    if (ch_q == last_ch(mask_q)) begin
                        sample_d = frame_bits & mask_q;
                        valid_d  = 1'b1;
                        fcnt_d   = fcnt_q + 8'd1;
                        shadow_d = '0;
                        if (stop_pend_q || (mask_in == '0)) begin
                            state_d     = IDLE;
                            ch_d        = '0;
                            stop_pend_d = 1'b0;
                        end else begin
                            ch_d   = first_ch(mask_in);
                            mask_d = mask_in;
                        end
                    end else begin
                        ch_d = next_ch(mask_q, ch_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            shadow_q    <= '0;
            sample_q    <= '0;
            mask_q      <= '1;
            stop_pend_q <= 1'b0;
            valid_q     <= 1'b0;
            fcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            shadow_q    <= shadow_d;
            sample_q    <= sample_d;
            mask_q      <= mask_d;
            stop_pend_q <= stop_pend_d;
            valid_q     <= valid_d;
            fcnt_q      <= fcnt_d;
        end
    end

    // ch_q is forced to 0 on every return to IDLE, so it drives the selects directly.
    assign s0           = ch_q[0];
    assign s1           = ch_q[1];
    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign busy         = (state_q == SCAN);
    assign frame_cnt    = fcnt_q;

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Randomized scoreboard bench for mux4_scan_ctrl (default build, all channels scanned).
module tb_mux4_scan_ctrl;

    localparam int DWELL  = 4;
    localparam int SETTLE = 1;
    localparam int FRAME  = 4 * DWELL;
    localparam int MAXC   = 6000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       mux_out = 1'b0;
    logic       s0, s1, sample_valid, busy;
    logic [3:0] sample;
    logic [7:0] frame_cnt;

    mux4_scan_ctrl #(.DWELL(DWELL), .SETTLE(SETTLE)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .mux_out      (mux_out),
        .s0           (s0),
        .s1           (s1),
        .sample       (sample),
        .sample_valid (sample_valid),
        .busy         (busy),
        .frame_cnt    (frame_cnt)
    );

    always #5 clk = ~clk;

    // cyc = number of rising edges seen; "interval k" is the time after edge k.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;
    int mode = 0;       // 0: random mux_out, 1: mux_out = s0, 2: mux_out = s1
    bit mon_en = 1'b0;
    int fc_model = 0;

    bit         mux_pat [MAXC];
    bit         exp_busy[MAXC];
    logic [1:0] exp_sel [MAXC];
    logic [3:0] exp_samp[MAXC];
    logic [7:0] exp_fc  [MAXC];

    typedef struct {
        int         cyc;
        logic [3:0] s;
        logic [7:0] fc;
    } exp_t;
    exp_t sbq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at interval %0d: got %0h, expected %0h", nm, cyc, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) step();
    endtask

    // Reference model: a scan accepted at edge e occupies intervals e..e+FRAME*nfr-1,
    // channel = offset/DWELL; frame f publishes at interval e+FRAME*(f+1).
    task automatic push_frames(input int e, input int nfr);
        for (int f = 0; f < nfr; f++) begin
            int         b;
            logic [3:0] s;
            exp_t       x;
            b = e + FRAME * f;
            for (int i = 0; i < FRAME; i++) begin
                exp_busy[b + i] = 1'b1;
                exp_sel[b + i]  = 2'(i / DWELL);
            end
            for (int k = 0; k < 4; k++) begin
                if (mode == 1)      s[k] = 1'((k % 2) != 0);
                else if (mode == 2) s[k] = 1'((k / 2) != 0);
                else                s[k] = mux_pat[b + DWELL * k + SETTLE];
            end
            fc_model = (fc_model + 1) % 256;
            x.cyc = b + FRAME;
            x.s   = s;
            x.fc  = 8'(fc_model);
            sbq.push_back(x);
            for (int t = b + FRAME; t < MAXC; t++) begin
                exp_samp[t] = s;
                exp_fc[t]   = 8'(fc_model);
            end
        end
    endtask

    task automatic apply_reset(input int r);
        for (int t = r; t < MAXC; t++) begin
            exp_busy[t] = 1'b0;
            exp_sel[t]  = 2'd0;
            exp_samp[t] = 4'd0;
            exp_fc[t]   = 8'd0;
        end
        while (sbq.size() > 0 && sbq[$].cyc >= r) void'(sbq.pop_back());
        fc_model = 0;
    endtask

    // rst_at > 0: reset sampled at edge e+rst_at, abandoning the scan.
    task automatic scan(input int nfr, input bit same_stop, input bit extra_start, input int rst_at);
        int e;
        int t;
        step();
        start = 1'b1;
        stop  = same_stop;
        e = cyc + 1;
        push_frames(e, nfr);
        step();
        start = 1'b0;
        stop  = 1'b0;
        if (rst_at > 0) begin
            wait_to(e + rst_at - 1);
            rst = 1'b1;
            apply_reset(e + rst_at);
            step();
            step();
            rst = 1'b0;
            return;
        end
        if (extra_start) begin
            wait_to(e + 2);
            start = 1'b1;
            step();
            start = 1'b0;
        end
        if (!same_stop) begin
            t = e + FRAME * (nfr - 1) + $urandom_range(1, FRAME - 1);
            wait_to(t - 1);
            stop = 1'b1;
            step();
            stop = 1'b0;
        end
        wait_to(e + FRAME * nfr + $urandom_range(1, 4));
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (cyc < MAXC) begin
                if (mode == 1)      mux_out = s0;
                else if (mode == 2) mux_out = s1;
                else                mux_out = mux_pat[cyc];
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en && cyc < MAXC) begin
            chk("busy", 32'(busy), 32'(exp_busy[cyc]));
            chk("select", 32'({s1, s0}), 32'(exp_sel[cyc]));
            chk("sample_hold", 32'(sample), 32'(exp_samp[cyc]));
            chk("frame_cnt", 32'(frame_cnt), 32'(exp_fc[cyc]));
            if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
                chk("valid_pulse", 32'(sample_valid), 32'd1);
                chk("valid_sample", 32'(sample), 32'(sbq[0].s));
                chk("valid_fcnt", 32'(frame_cnt), 32'(sbq[0].fc));
                void'(sbq.pop_front());
            end else begin
                chk("no_valid", 32'(sample_valid), 32'd0);
            end
        end
    end

    initial begin
        for (int t = 0; t < MAXC; t++) begin
            mux_pat[t]  = 1'($urandom_range(0, 1));
            exp_busy[t] = 1'b0;
            exp_sel[t]  = 2'd0;
            exp_samp[t] = 4'd0;
            exp_fc[t]   = 8'd0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_select", 32'({s1, s0}), 32'd0);
        chk("rst_sample", 32'(sample), 32'd0);
        chk("rst_valid", 32'(sample_valid), 32'd0);
        chk("rst_fcnt", 32'(frame_cnt), 32'd0);

        mode = 0;
        scan(1, 1'b0, 1'b0, 0);
        chk("fcnt_first", 32'(frame_cnt), 32'd1);

        mode = 1;
        scan(3, 1'b0, 1'b1, 0);
        mode = 2;
        scan(2, 1'b0, 1'b0, 0);
        mode = 0;
        scan(1, 1'b1, 1'b0, 0);

        scan(2, 1'b0, 1'b0, 10);
        chk("fcnt_after_rst", 32'(frame_cnt), 32'd0);
        chk("sample_after_rst", 32'(sample), 32'd0);
        scan(2, 1'b0, 1'b0, 0);

        step();
        rst = 1'b1;
        apply_reset(cyc + 1);
        step();
        step();
        rst = 1'b0;
        scan(256, 1'b0, 1'b0, 0);
        chk("fcnt_wrap", 32'(frame_cnt), 32'd0);
        chk("idle_after_256", 32'(busy), 32'd0);

        repeat (5) step();
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
